// File: rtl/rnd_rb_arb_pkg.sv
// Shared definitions for the round-robin packet arbiter rnd_rb_arb:
// FSM state encoding, default forced-release timeout and an index helper.
package rnd_rb_arb_pkg;

  // IDLE: no grant outstanding. BUSY: one requester owns the grant.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Default number of cycles a grant may be held before a forced release.
  localparam int ARB_TIMEOUT_DEF = 1024;

  // Wrap an index that may exceed the port count by less than one full turn.
  function automatic int rr_wrap(input int idx, input int width);
    return (idx >= width) ? (idx - width) : idx;
  endfunction

endpackage

// File: rtl/rnd_rb_ppe.sv
// Combinational programmable-priority encoder. Port rr_priority has the
// highest priority, followed by rr_priority+1, ... wrapping around.
module rnd_rb_ppe
  import rnd_rb_arb_pkg::*;
#(
  parameter int RR_WIDTH    = 8,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH)
) (
  input  logic [RR_WIDTH-1:0]    rr_vec_in,
  input  logic [RR_WIDTH_L2-1:0] rr_priority,
  output logic                   rr_vld_out,
  output logic [RR_WIDTH-1:0]    rr_vec_out,
  output logic [RR_WIDTH_L2-1:0] rr_bin_out
);

  logic [RR_WIDTH_L2-1:0] idx;

  // Scan from the lowest priority offset upward so the highest-priority hit
  // is the last one written and therefore wins.
  always_comb begin
    rr_vld_out = 1'b0;
    rr_vec_out = '0;
    rr_bin_out = '0;
    idx        = '0;
    for (int i = RR_WIDTH - 1; i >= 0; i--) begin
      idx = RR_WIDTH_L2'(rr_wrap(int'(rr_priority) + i, RR_WIDTH));
      if (rr_vec_in[idx]) begin
        rr_vld_out      = 1'b1;
        rr_vec_out      = '0;
        rr_vec_out[idx] = 1'b1;
        rr_bin_out      = idx;
      end
    end
  end

endmodule

// File: rtl/rnd_rb_arb.sv
// Round-robin packet arbiter with a registered grant.
// Optional forced release after ARB_TIMEOUT busy cycles is compiled in when
// the macro RND_RB_ARB_TIMEOUT_EN is defined; otherwise grants last until done.
//
// Handshake: grant_vld=1 means grant_vec/grant_bin name the owner and stay
// constant; the owner ends its grant with a one-cycle done pulse while
// grant_vld=1 (done with grant_vld=0 is ignored). req is level-sensitive and
// is not a valid/ready pair: dropping req does not end an active grant.
module rnd_rb_arb
  import rnd_rb_arb_pkg::*;
#(
  parameter int RR_WIDTH    = 8,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH),
  parameter int ARB_TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [RR_WIDTH-1:0]    req,
  input  logic                   done,
  output logic                   grant_vld,
  output logic [RR_WIDTH-1:0]    grant_vec,
  output logic [RR_WIDTH_L2-1:0] grant_bin,
  output logic                   timeout_err,
  output arb_state_e             state_dbg
);

  arb_state_e             state_q, state_d;
  logic [RR_WIDTH_L2-1:0] ptr_q, ptr_nxt;
  logic [RR_WIDTH-1:0]    vec_q, vec_d;
  logic [RR_WIDTH_L2-1:0] bin_q, bin_d;
  logic                   release_ev;
  logic                   timeout_hit;
  logic                   grant_load;
  logic                   ppe_vld;
  logic [RR_WIDTH-1:0]    ppe_vec;
  logic [RR_WIDTH_L2-1:0] ppe_bin;

  // A release is either the consumer's done or a forced timeout, only in BUSY.
  assign release_ev = (state_q == ARB_BUSY) && (done || timeout_hit);

  // The encoder sees the pointer as it will be after this cycle's release, so
  // a back-to-back re-arbitration already treats the old owner as lowest.
  always_comb begin
    ptr_nxt = ptr_q;
    if (release_ev) begin
      if (bin_q == RR_WIDTH_L2'(RR_WIDTH - 1)) ptr_nxt = '0;
      else                                     ptr_nxt = bin_q + RR_WIDTH_L2'(1);
    end
  end

  rnd_rb_ppe #(
    .RR_WIDTH    (RR_WIDTH),
    .RR_WIDTH_L2 (RR_WIDTH_L2)
  ) u_ppe (
    .rr_vec_in   (req),
    .rr_priority (ptr_nxt),
    .rr_vld_out  (ppe_vld),
    .rr_vec_out  (ppe_vec),
    .rr_bin_out  (ppe_bin)
  );

  // Next-state and next-grant decode; the grant is locked while BUSY.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    bin_d      = bin_q;
    grant_load = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (ppe_vld) begin
          state_d    = ARB_BUSY;
          vec_d      = ppe_vec;
          bin_d      = ppe_bin;
          grant_load = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (release_ev) begin
          if (ppe_vld) begin
            vec_d      = ppe_vec;
            bin_d      = ppe_bin;
            grant_load = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            vec_d   = '0;
            bin_d   = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        vec_d   = '0;
        bin_d   = '0;
      end
    endcase
  end

  // State, grant and pointer registers; the pointer only moves on release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      vec_q   <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_nxt;
      vec_q   <= vec_d;
      bin_q   <= bin_d;
    end
  end

`ifdef RND_RB_ARB_TIMEOUT_EN
  localparam int CNT_W = (ARB_TIMEOUT > 1) ? $clog2(ARB_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Timeout fires on the last allowed busy cycle unless done arrives with it.
  assign timeout_hit = (state_q == ARB_BUSY) &&
                       (cnt_q == CNT_W'(ARB_TIMEOUT - 1)) && !done;

  // Busy-cycle counter restarts at zero with every new grant.
  always_comb begin
    cnt_d = '0;
    if (grant_load)                 cnt_d = '0;
    else if (state_q == ARB_BUSY)   cnt_d = cnt_q + CNT_W'(1);
  end

  // Busy-cycle counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign grant_vld   = (state_q == ARB_BUSY);
  assign grant_vec   = vec_q;
  assign grant_bin   = bin_q;
  assign timeout_err = timeout_hit;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_rnd_rb_arb.sv
// Self-checking bench for rnd_rb_arb: directed scenarios followed by random
// traffic, all compared against a behavioural round-robin model.
module tb_rnd_rb_arb;
  import rnd_rb_arb_pkg::*;

  localparam int W   = 8;
  localparam int WL2 = 3;
  localparam int TMO = 16;
`ifdef RND_RB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic           clk  = 1'b0;
  logic           rstn = 1'b1;
  logic [W-1:0]   req  = '0;
  logic           done = 1'b0;
  logic           grant_vld;
  logic [W-1:0]   grant_vec;
  logic [WL2-1:0] grant_bin;
  logic           timeout_err;
  arb_state_e     state_dbg;

  always #5 clk = ~clk;

  rnd_rb_arb #(
    .RR_WIDTH    (W),
    .RR_WIDTH_L2 (WL2),
    .ARB_TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .done        (done),
    .grant_vld   (grant_vld),
    .grant_vec   (grant_vec),
    .grant_bin   (grant_bin),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] exp_q[$];
  bit           m_busy = 1'b0;
  int           m_bin  = 0;
  int           m_ptr  = 0;
  int           m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester found walking upward from the priority pointer.
  function automatic int winner(input logic [W-1:0] r, input int p);
    int idx;
    for (int i = 0; i < W; i++) begin
      idx = (p + i) % W;
      if (r[WL2'(idx)]) return idx;
    end
    return 0;
  endfunction

  task automatic check_outputs();
    logic [W-1:0] e_vec;
    e_vec = exp_q.pop_front();
    check("grant_vec", 32'(grant_vec), 32'(e_vec));
    check("grant_vld", 32'(grant_vld), 32'(m_busy));
    check("grant_bin", 32'(grant_bin), 32'(m_busy ? m_bin : 0));
    check("state_dbg", 32'(state_dbg), 32'(m_busy ? ARB_BUSY : ARB_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive at the falling edge, check the pulse before the rising
  // edge, advance the model on the edge and check registered outputs after it.
  task automatic cycle(input logic [W-1:0] r, input logic d, output logic te_obs);
    logic te_exp;
    logic rel;
    @(negedge clk);
    req  = r;
    done = d;
    #1;
    te_exp = TMO_EN && m_busy && (m_cnt == TMO - 1) && !d;
    te_obs = timeout_err;
    check("timeout_err", 32'(timeout_err), 32'(te_exp));
    @(posedge clk);
    rel = m_busy && (d || te_exp);
    if (!m_busy) begin
      if (r != '0) begin
        m_busy = 1'b1;
        m_bin  = winner(r, m_ptr);
        m_cnt  = 0;
      end
    end else if (rel) begin
      m_ptr = (m_bin + 1) % W;
      if (r != '0) begin
        m_bin = winner(r, m_ptr);
        m_cnt = 0;
      end else begin
        m_busy = 1'b0;
        m_bin  = 0;
      end
    end else begin
      m_cnt++;
    end
    exp_q.push_back(m_busy ? (W'(1) << m_bin) : W'(0));
    #1;
    check_outputs();
  endtask

  task automatic step(input logic [W-1:0] r, input logic d);
    logic te;
    cycle(r, d, te);
  endtask

  task automatic expect_grant(input string tag, input int bin);
    check({tag, "_vld"}, 32'(grant_vld), 32'(1));
    check({tag, "_bin"}, 32'(grant_bin), 32'(bin));
  endtask

  // Assert reset away from any clock edge and check that outputs clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_vld", 32'(grant_vld), 32'(0));
    check("rst_vec", 32'(grant_vec), 32'(0));
    check("rst_bin", 32'(grant_bin), 32'(0));
    check("rst_tmo", 32'(timeout_err), 32'(0));
    check("rst_state", 32'(state_dbg), 32'(ARB_IDLE));
    m_busy = 1'b0;
    m_bin  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    req    = '0;
    done   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic         te;
    logic [W-1:0] r;
    logic         d;

    async_reset();

    // Idle with no requests, including done pulses that must be ignored.
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    // Full rotation with every port requesting and done on every grant.
    step(8'hFF, 1'b0);
    expect_grant("rot0", 0);
    for (int i = 1; i <= 8; i++) begin
      step(8'hFF, 1'b1);
      expect_grant("rot", i % 8);
    end
    step(8'h00, 1'b1);

    // Reset while port 5 holds the grant, then re-arbitrate from pointer 0.
    step(8'h20, 1'b0);
    expect_grant("pre_rst", 5);
    step(8'h20, 1'b0);
    async_reset();
    step(8'h20, 1'b0);
    expect_grant("post_rst", 5);
    step(8'h00, 1'b1);

    // Pointer wrap from port 7 to port 0.
    step(8'h40, 1'b0);
    expect_grant("wrap6", 6);
    step(8'h81, 1'b1);
    expect_grant("wrap7", 7);
    step(8'h81, 1'b1);
    expect_grant("wrap0", 0);
    step(8'h00, 1'b1);

    // done while idle must not move the pointer (pointer is 2 here).
    step(8'h03, 1'b0);
    expect_grant("idle_pre", 1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h03, 1'b0);
    expect_grant("idle_done", 0);
    step(8'h00, 1'b1);

    // Packet lock: port 3 keeps the grant after dropping its request.
    step(8'h08, 1'b0);
    expect_grant("lock_a", 3);
    for (int i = 0; i < 3; i++) begin
      step(8'h10, 1'b0);
      expect_grant("lock_hold", 3);
    end
    step(8'h10, 1'b1);
    expect_grant("lock_next", 4);

    // Sole requester is re-granted back to back.
    step(8'h04, 1'b1);
    expect_grant("sole_a", 2);
    step(8'h04, 1'b1);
    expect_grant("sole_b", 2);
    step(8'h00, 1'b1);

    // Grant held without done: forced release on the 16th busy cycle when the
    // timeout is built in, otherwise held for the whole window.
    step(8'h04, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      cycle(8'h00, 1'b0, te);
      check("tmo_pulse", 32'(te), 32'(TMO_EN && (k == TMO)));
      check("tmo_hold", 32'(grant_vld), 32'(TMO_EN ? (k < TMO) : 1'b1));
    end
    step(8'h00, 1'b1);

    // done arriving on the timeout cycle is an ordinary release; the counter
    // then restarts for the new grant.
    step(8'h04, 1'b0);
    for (int k = 1; k < TMO; k++) step(8'h04, 1'b0);
    cycle(8'h04, 1'b1, te);
    check("tmo_done", 32'(te), 32'(0));
    expect_grant("tmo_regrant", 2);
    for (int k = 1; k <= TMO + 2; k++) step(8'h04, 1'b0);
    step(8'h00, 1'b1);

    // Random traffic against the model, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      if ($urandom_range(0, 4) == 0) r = '0;
      else r = W'($urandom_range(0, 255)) & W'($urandom_range(0, 255));
      d = ($urandom_range(0, 2) == 0);
      step(r, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
